// File: rtl/inst_loader_pkg.sv
// Shared state encoding and default parameters for the instruction-memory preload controller.
package inst_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    CHECK,
    RELEASE,
    RUN,
    ERROR
  } state_e;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_ADDR_W      = 64;
  localparam int DEF_DEPTH       = 1024;
  localparam int DEF_BASE_ADDR   = 1;
  localparam int DEF_CHECKSUM_EN = 1;
  localparam int DEF_RELEASE_CYC = 2;

  // States in which the host stream is being consumed.
  function automatic logic takes_words(state_e s);
    return (s == HDR) || (s == LOAD) || (s == CHECK);
  endfunction

  function automatic logic is_busy(state_e s);
    return takes_words(s) || (s == RELEASE);
  endfunction

endpackage

// File: rtl/inst_loader.sv
// Preloads a length-prefixed, optionally checksummed program image into instruction SRAM
// while holding the core in reset, then releases it or parks it with a sticky error.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int BASE_ADDR   = DEF_BASE_ADDR,
  parameter int CHECKSUM_EN = DEF_CHECKSUM_EN,
  parameter int RELEASE_CYC = DEF_RELEASE_CYC
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_W-1:0]          s_data,
  output logic                       inst_sram_wen,
  output logic [ADDR_W-1:0]          inst_sram_waddr,
  output logic [DATA_W-1:0]          inst_sram_wdata,
  output logic                       cpu_reset,
  output logic                       inst_sram_en_toif,
  output logic                       busy,
  output logic                       err,
  output logic [$clog2(DEPTH+1)-1:0] words_loaded
);

  localparam int                 CNT_W     = $clog2(DEPTH + 1);
  localparam int                 REL_W     = $clog2(RELEASE_CYC + 1);
  localparam logic [DATA_W:0]    DEPTH_EXT = (DATA_W + 1)'(DEPTH);
  localparam logic [REL_W-1:0]   REL_LAST  = REL_W'(RELEASE_CYC - 1);
  localparam logic [ADDR_W-1:0]  BASE      = ADDR_W'(BASE_ADDR);

  state_e             state_q, state_d;
  logic               accept, hdr_bad, last_word;
  logic               s_ready_q, wen_q, cpu_reset_q, fetch_en_q, busy_q, err_q;
  logic [ADDR_W-1:0]  waddr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [REL_W-1:0]   rel_cnt_q;
  logic [CNT_W-1:0]   n_q;
  logic [DATA_W-1:0]  sum_q;

  always_comb begin
    accept    = s_valid && s_ready_q;
    hdr_bad   = (s_data == '0) || ({1'b0, s_data} > DEPTH_EXT);
    last_word = (cnt_q + CNT_W'(1)) == n_q;
    state_d   = state_q;
    case (state_q)
      IDLE:    if (start) state_d = HDR;
      HDR:     if (accept) state_d = hdr_bad ? ERROR : LOAD;
      LOAD:    if (accept && last_word) state_d = (CHECKSUM_EN != 0) ? CHECK : RELEASE;
      CHECK:   if (accept) state_d = (s_data == sum_q) ? RELEASE : ERROR;
      RELEASE: if (rel_cnt_q == REL_LAST) state_d = RUN;
      RUN:     if (start) state_d = HDR;
      ERROR:   if (start) state_d = HDR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Stage p1: control outputs decoded from next state, write port registered one cycle behind accept
  always_ff @(posedge clk) begin
    if (reset) begin
      s_ready_q   <= 1'b0;
      wen_q       <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      cpu_reset_q <= 1'b1;
      fetch_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      rel_cnt_q   <= '0;
    end else begin
      s_ready_q   <= takes_words(state_d);
      busy_q      <= is_busy(state_d);
      err_q       <= (state_d == ERROR);
      cpu_reset_q <= (state_d != RUN);
      fetch_en_q  <= (state_d == RUN);
      wen_q       <= 1'b0;
      rel_cnt_q   <= (state_q == RELEASE) ? rel_cnt_q + REL_W'(1) : '0;
      if (state_q == HDR && accept && !hdr_bad) cnt_q <= '0;
      if (state_q == LOAD && accept) begin
        wen_q   <= 1'b1;
        waddr_q <= BASE + ADDR_W'(cnt_q);
        wdata_q <= s_data;
        cnt_q   <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Length and running checksum are pure data; they are always re-seeded by a valid header.
  always_ff @(posedge clk) begin
    if (state_q == HDR && accept && !hdr_bad) begin
      n_q   <= CNT_W'(s_data);
      sum_q <= '0;
    end else if (state_q == LOAD && accept) begin
      sum_q <= sum_q + s_data;
    end
  end

  assign s_ready           = s_ready_q;
  assign inst_sram_wen     = wen_q;
  assign inst_sram_waddr   = waddr_q;
  assign inst_sram_wdata   = wdata_q;
  assign cpu_reset         = cpu_reset_q;
  assign inst_sram_en_toif = fetch_en_q;
  assign busy              = busy_q;
  assign err               = err_q;
  assign words_loaded      = cnt_q;

endmodule

// File: tb/tb_inst_loader.sv
// Randomised self-checking bench: one loader with checksum, one without, against an image-level model.
module tb_inst_loader;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 64;
  localparam int DEPTH  = 1024;
  localparam int RC     = 2;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic              start_w [2];
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready_w [2];
  logic              wen_w [2];
  logic [ADDR_W-1:0] waddr_w [2];
  logic [DATA_W-1:0] wdata_w [2];
  logic              rst_w [2];
  logic              fetch_w [2];
  logic              busy_w [2];
  logic              err_w [2];
  logic [CNT_W-1:0]  wl_w [2];

  inst_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(1),
                .CHECKSUM_EN(1), .RELEASE_CYC(RC)) dut_cs (
    .clk(clk), .reset(reset), .start(start_w[0]), .s_valid(s_valid), .s_ready(s_ready_w[0]),
    .s_data(s_data), .inst_sram_wen(wen_w[0]), .inst_sram_waddr(waddr_w[0]),
    .inst_sram_wdata(wdata_w[0]), .cpu_reset(rst_w[0]), .inst_sram_en_toif(fetch_w[0]),
    .busy(busy_w[0]), .err(err_w[0]), .words_loaded(wl_w[0]));

  inst_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(1),
                .CHECKSUM_EN(0), .RELEASE_CYC(RC)) dut_nc (
    .clk(clk), .reset(reset), .start(start_w[1]), .s_valid(s_valid), .s_ready(s_ready_w[1]),
    .s_data(s_data), .inst_sram_wen(wen_w[1]), .inst_sram_waddr(waddr_w[1]),
    .inst_sram_wdata(wdata_w[1]), .cpu_reset(rst_w[1]), .inst_sram_en_toif(fetch_w[1]),
    .busy(busy_w[1]), .err(err_w[1]), .words_loaded(wl_w[1]));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } wr_t;

  wr_t               wq[$];
  int                acc_q[$];
  logic [DATA_W-1:0] img[$];
  int                mon_sel = 0;
  int                fall_cyc = -1;
  logic              prev_rst = 1'b1;
  bit                tgl_ph = 1'b0;
  int                checks = 0;
  int                errors = 0;

  // Observed SRAM writes and the cycle the core leaves reset, for the DUT under test.
  always @(negedge clk) begin
    if (wen_w[mon_sel]) wq.push_back('{waddr_w[mon_sel], wdata_w[mon_sel], cyc});
    if (prev_rst && !rst_w[mon_sel] && fall_cyc < 0) fall_cyc = cyc;
    prev_rst = rst_w[mon_sel];
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] img_sum();
    logic [DATA_W-1:0] s = '0;
    foreach (img[i]) s += img[i];
    return s;
  endfunction

  // mode 0: always valid, 1: valid toggles every cycle, 2: random stalls
  task automatic send_word(input logic [DATA_W-1:0] w, input int mode, output int acc);
    int  guard = 0;
    bit  done = 1'b0;
    acc    = -1;
    s_data = w;
    while (!done) begin
      case (mode)
        0:       s_valid = 1'b1;
        1:       begin s_valid = tgl_ph; tgl_ph = !tgl_ph; end
        default: s_valid = ($urandom_range(0, 3) != 0);
      endcase
      @(negedge clk);
      if (s_valid && s_ready_w[mon_sel]) begin
        acc  = cyc;
        done = 1'b1;
      end else if (guard > 40) begin
        check_val("hs_timeout", 64'(s_ready_w[mon_sel]), 64'd1);
        done = 1'b1;
      end
      guard++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_idle(input int k, input string tag);
    check_val({tag, ".s_ready"}, 64'(s_ready_w[k]), 64'd0);
    check_val({tag, ".wen"},     64'(wen_w[k]),     64'd0);
    check_val({tag, ".waddr"},   waddr_w[k],        64'd0);
    check_val({tag, ".wdata"},   64'(wdata_w[k]),   64'd0);
    check_val({tag, ".cpu_rst"}, 64'(rst_w[k]),     64'd1);
    check_val({tag, ".fetch"},   64'(fetch_w[k]),   64'd0);
    check_val({tag, ".busy"},    64'(busy_w[k]),    64'd0);
    check_val({tag, ".err"},     64'(err_w[k]),     64'd0);
    check_val({tag, ".wl"},      64'(wl_w[k]),      64'd0);
  endtask

  task automatic pulse_start(input int sel, input string tag);
    start_w[sel] = 1'b1;
    @(posedge clk);
    #1;
    start_w[sel] = 1'b0;
    @(negedge clk);
    check_val({tag, ".hdr_cpu_rst"}, 64'(rst_w[sel]),   64'd1);
    check_val({tag, ".hdr_fetch"},   64'(fetch_w[sel]), 64'd0);
    check_val({tag, ".hdr_busy"},    64'(busy_w[sel]),  64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic load_image(input int sel, input logic [DATA_W-1:0] n_hdr, input bit send_cs,
                            input logic [DATA_W-1:0] cs, input int mode, input string tag,
                            output int last_acc);
    int a;
    mon_sel  = sel;
    wq.delete();
    acc_q.delete();
    fall_cyc = -1;
    pulse_start(sel, tag);
    send_word(n_hdr, mode, a);
    last_acc = a;
    if (n_hdr >= 1 && n_hdr <= DEPTH) begin
      foreach (img[i]) begin
        send_word(img[i], mode, a);
        acc_q.push_back(a);
        last_acc = a;
      end
      if (send_cs) begin
        send_word(cs, mode, a);
        last_acc = a;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic verify(input int sel, input logic [DATA_W-1:0] n_hdr, input bit cs_en,
                        input logic [DATA_W-1:0] cs, input int last_acc, input string tag);
    bit hdr_ok, ok;
    int nexp;
    hdr_ok = (n_hdr != 0) && (n_hdr <= DEPTH);
    ok     = hdr_ok && (!cs_en || cs == img_sum());
    nexp   = hdr_ok ? img.size() : 0;
    repeat (RC + 4) @(negedge clk);
    check_val({tag, ".nwr"}, 64'(wq.size()), 64'(nexp));
    for (int i = 0; i < wq.size() && i < nexp; i++) begin
      check_val({tag, ".addr"}, wq[i].addr,      64'(1 + i));
      check_val({tag, ".data"}, 64'(wq[i].data), 64'(img[i]));
      check_val({tag, ".wcyc"}, 64'(wq[i].cyc),  64'(acc_q[i] + 1));
    end
    if (hdr_ok) check_val({tag, ".words"}, 64'(wl_w[sel]), 64'(nexp));
    check_val({tag, ".err"},     64'(err_w[sel]),     64'(!ok));
    check_val({tag, ".cpu_rst"}, 64'(rst_w[sel]),     64'(!ok));
    check_val({tag, ".fetch"},   64'(fetch_w[sel]),   64'(ok));
    check_val({tag, ".busy"},    64'(busy_w[sel]),    64'd0);
    check_val({tag, ".s_ready"}, 64'(s_ready_w[sel]), 64'd0);
    if (ok) check_val({tag, ".fall"}, 64'(fall_cyc), 64'(last_acc + 1 + RC));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int               la, n, a;
    logic [DATA_W-1:0] cs;
    reset      = 1'b1;
    start_w[0] = 1'b0;
    start_w[1] = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle(0, "rst_cs");
    check_idle(1, "rst_nc");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Known image with correct checksum, then with a corrupted one.
    img = '{32'h01400113, 32'h00100A13, 32'h00100A13, 32'h00100A13, 32'h00510193};
    load_image(0, 5, 1'b1, 32'h01C120DF, 0, "basic", la);
    verify(0, 5, 1'b1, 32'h01C120DF, la, "basic");

    img = '{$urandom(), $urandom()};
    load_image(0, 2, 1'b1, img_sum(), 0, "reload", la);
    verify(0, 2, 1'b1, img_sum(), la, "reload");

    img = '{32'h01400113, 32'h00100A13, 32'h00100A13, 32'h00100A13, 32'h00510193};
    load_image(0, 5, 1'b1, 32'h01C120DE, 0, "badcs", la);
    verify(0, 5, 1'b1, 32'h01C120DE, la, "badcs");

    img.delete();
    load_image(0, 0, 1'b1, 0, 0, "n0", la);
    verify(0, 0, 1'b1, 0, la, "n0");
    load_image(0, DEPTH + 1, 1'b1, 0, 0, "n1025", la);
    verify(0, DEPTH + 1, 1'b1, 0, la, "n1025");

    img.delete();
    for (int i = 0; i < 8; i++) img.push_back($urandom());
    load_image(0, 8, 1'b1, img_sum(), 1, "toggle", la);
    verify(0, 8, 1'b1, img_sum(), la, "toggle");

    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 16);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back($urandom());
      cs = img_sum() ^ (($urandom_range(0, 2) == 0) ? 32'(1 << $urandom_range(0, 31)) : 32'd0);
      load_image(0, n, 1'b1, cs, 2, "rand", la);
      verify(0, n, 1'b1, cs, la, "rand");
    end

    // Reset after three of five words, then a clean reload.
    img.delete();
    for (int i = 0; i < 5; i++) img.push_back($urandom());
    mon_sel = 0;
    wq.delete();
    pulse_start(0, "midrst");
    send_word(5, 0, a);
    for (int i = 0; i < 3; i++) send_word(img[i], 0, a);
    s_valid = 1'b0;
    reset   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle(0, "midrst");
    check_val("midrst.nwr", 64'(wq.size()), 64'd3);
    @(posedge clk);
    #1;
    reset = 1'b0;
    load_image(0, 5, 1'b1, img_sum(), 0, "afterrst", la);
    verify(0, 5, 1'b1, img_sum(), la, "afterrst");

    // Full-depth image on the loader without a checksum word.
    img.delete();
    for (int i = 0; i < DEPTH; i++) img.push_back($urandom());
    load_image(1, DEPTH, 1'b0, 0, 0, "full", la);
    verify(1, DEPTH, 1'b0, 0, la, "full");
    check_val("full.last_addr", (wq.size() > 0) ? wq[wq.size()-1].addr : 64'd0, 64'(DEPTH));

    img.delete();
    load_image(1, DEPTH + 1, 1'b0, 0, 0, "nc_n1025", la);
    verify(1, DEPTH + 1, 1'b0, 0, la, "nc_n1025");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
